// File: rtl/lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lock_sequencer
// Brief    : Keypad combination-lock sequencer (program, entry, open,
//            lockout and alarm timing) driving an external code register.
// Revision : 1.0 - initial release
// ============================================================================
module lock_sequencer #(
    parameter int DIGITS        = 8,
    parameter int MAX_TRIES     = 3,
    parameter int OPEN_TICKS    = 500,
    parameter int LOCKOUT_TICKS = 1000,
    parameter int IDLE_TICKS    = 300
) (
    input  logic                  hz100,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [4:0]            key_code,
    input  logic [4*DIGITS-1:0]   stored_code,
    output logic                  code_wr,
    output logic                  code_clr,
    output logic [2:0]            state,
    output logic [2:0]            digit_idx,
    output logic [1:0]            tries_left,
    output logic                  unlocked,
    output logic                  alarm
);

    localparam logic [2:0] S_SET     = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_ENTRY   = 3'd2;
    localparam logic [2:0] S_OPEN    = 3'd3;
    localparam logic [2:0] S_LOCKOUT = 3'd4;
    localparam logic [2:0] S_ALARM   = 3'd5;

    localparam logic [3:0]  c_DIGITS       = 4'(DIGITS);
    localparam logic [3:0]  c_LAST_IDX     = 4'(DIGITS - 1);
    localparam logic [1:0]  c_MAX_TRIES    = 2'(MAX_TRIES);
    localparam logic [15:0] c_OPEN_LOAD    = 16'(OPEN_TICKS - 1);
    localparam logic [15:0] c_LOCKOUT_LOAD = 16'(LOCKOUT_TICKS - 1);
    localparam logic [15:0] c_IDLE_LOAD    = 16'(IDLE_TICKS - 1);

    logic [2:0]  r_state;
    logic [3:0]  r_count;
    logic [1:0]  r_tries;
    logic [15:0] r_timer;
    logic        r_mismatch;
    logic        r_unlocked;
    logic        r_alarm;

    logic [2:0]  w_state_nxt;
    logic [3:0]  w_count_nxt;
    logic [1:0]  w_tries_nxt;
    logic [15:0] w_timer_nxt;
    logic        w_mismatch_nxt;
    logic        w_code_wr;
    logic        w_code_clr;
    logic [3:0]  w_exp_digit;
    logic        w_mis_any;
    logic        w_key_hex;
    logic        w_key_start;
    logic        w_key_clear;
    logic        w_key_set;
    logic        w_expired;

    assign w_key_hex   = key_valid && (key_code < 5'd16);
    assign w_key_start = key_valid && (key_code == 5'd16);
    assign w_key_clear = key_valid && (key_code == 5'd17);
    assign w_key_set   = key_valid && (key_code == 5'd18);
    assign w_expired   = (r_timer == 16'd0);

    // Expected nibble for the current entry position, first digit in the MSBs.
    always_comb begin
        w_exp_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_count == 4'(i)) begin
                w_exp_digit = stored_code[4*(DIGITS-1-i) +: 4];
            end
        end
    end

    assign w_mis_any = r_mismatch || (key_code[3:0] != w_exp_digit);

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_tries_nxt    = r_tries;
        w_timer_nxt    = r_timer;
        w_mismatch_nxt = r_mismatch;
        w_code_wr      = 1'b0;
        w_code_clr     = 1'b0;
        case (r_state)
            S_SET: begin
                if (w_key_hex) begin
                    w_code_wr = 1'b1;
                    if (r_count != c_DIGITS) begin
                        w_count_nxt = r_count + 4'd1;
                    end
                end else if (w_key_clear) begin
                    w_code_clr  = 1'b1;
                    w_count_nxt = 4'd0;
                end else if (w_key_start && (r_count == c_DIGITS)) begin
                    w_state_nxt = S_IDLE;
                    w_tries_nxt = c_MAX_TRIES;
                end
            end
            S_IDLE: begin
                if (w_key_start) begin
                    w_state_nxt    = S_ENTRY;
                    w_count_nxt    = 4'd0;
                    w_mismatch_nxt = 1'b0;
                    w_timer_nxt    = c_IDLE_LOAD;
                end
            end
            S_ENTRY: begin
                // Expiry is checked first so a key on the last idle cycle is dropped.
                if (w_expired) begin
                    w_state_nxt    = S_IDLE;
                    w_count_nxt    = 4'd0;
                    w_mismatch_nxt = 1'b0;
                end else if (w_key_hex) begin
                    w_timer_nxt = c_IDLE_LOAD;
                    if (r_count == c_LAST_IDX) begin
                        w_count_nxt    = 4'd0;
                        w_mismatch_nxt = 1'b0;
                        if (!w_mis_any) begin
                            w_state_nxt = S_OPEN;
                            w_tries_nxt = c_MAX_TRIES;
                            w_timer_nxt = c_OPEN_LOAD;
                        end else if (r_tries > 2'd1) begin
                            w_state_nxt = S_LOCKOUT;
                            w_tries_nxt = r_tries - 2'd1;
                            w_timer_nxt = c_LOCKOUT_LOAD;
                        end else begin
                            w_state_nxt = S_ALARM;
                            w_tries_nxt = 2'd0;
                        end
                    end else begin
                        w_count_nxt    = r_count + 4'd1;
                        w_mismatch_nxt = w_mis_any;
                    end
                end else if (key_valid) begin
                    w_timer_nxt = c_IDLE_LOAD;
                    if (w_key_clear) begin
                        w_count_nxt    = 4'd0;
                        w_mismatch_nxt = 1'b0;
                    end
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            S_OPEN: begin
                if (w_expired) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                    if (w_key_start) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_key_set) begin
                        w_state_nxt = S_SET;
                        w_code_clr  = 1'b1;
                        w_count_nxt = 4'd0;
                    end
                end
            end
            S_LOCKOUT: begin
                if (w_expired) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            S_ALARM: begin
                w_state_nxt = S_ALARM;
            end
            default: begin
                w_state_nxt = S_SET;
                w_count_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            r_state    <= S_SET;
            r_count    <= 4'd0;
            r_tries    <= c_MAX_TRIES;
            r_timer    <= 16'd0;
            r_mismatch <= 1'b0;
            r_unlocked <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_tries    <= w_tries_nxt;
            r_timer    <= w_timer_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_unlocked <= (w_state_nxt == S_OPEN);
            r_alarm    <= (w_state_nxt == S_ALARM);
        end
    end

    // Strobes are combinational with the key; held low while reset is applied.
    assign code_wr    = w_code_wr  && !reset;
    assign code_clr   = w_code_clr && !reset;
    assign state      = r_state;
    assign digit_idx  = r_count[2:0];
    assign tries_left = r_tries;
    assign unlocked   = r_unlocked;
    assign alarm      = r_alarm;

endmodule
`default_nettype wire

// File: tb/tb_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_sequencer
// Brief    : Directed, table-driven self-checking bench for lock_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lock_sequencer;

    logic        hz100 = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [31:0] stored_code;
    logic        code_wr;
    logic        code_clr;
    logic [2:0]  state;
    logic [2:0]  digit_idx;
    logic [1:0]  tries_left;
    logic        unlocked;
    logic        alarm;

    int checks = 0;
    int errors = 0;

    lock_sequencer dut (
        .hz100       (hz100),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .stored_code (stored_code),
        .code_wr     (code_wr),
        .code_clr    (code_clr),
        .state       (state),
        .digit_idx   (digit_idx),
        .tries_left  (tries_left),
        .unlocked    (unlocked),
        .alarm       (alarm)
    );

    always #5 hz100 = ~hz100;

    typedef struct {
        logic [4:0] kc;
        logic [2:0] st;
        logic [2:0] idx;
        logic [1:0] tr;
        logic       wr;
        logic       clr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Drive one key for one cycle; strobes are sampled mid-cycle.
    task automatic press(input logic [4:0] kc, output logic wr, output logic clr);
        key_valid = 1'b1;
        key_code  = kc;
        #3;
        wr  = code_wr;
        clr = code_clr;
        @(posedge hz100);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge hz100);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        key_valid = 1'b0;
        @(posedge hz100);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_idx"}, 32'(digit_idx), 32'd0);
        chk({tag, "_tries"}, 32'(tries_left), 32'd3);
        chk({tag, "_outs"}, {28'd0, code_wr, code_clr, unlocked, alarm}, 32'd0);
    endtask

    task automatic program_code();
        logic wr, clr;
        for (int d = 1; d <= 8; d++) press(5'(d), wr, clr);
        press(5'd16, wr, clr);
    endtask

    task automatic enter_code(input logic [31:0] code);
        logic wr, clr;
        logic [31:0] c;
        c = code;
        press(5'd16, wr, clr);
        for (int i = 0; i < 8; i++) press({1'b0, c[31-4*i -: 4]}, wr, clr);
    endtask

    // Number of consecutive cycles spent in state s, bounded.
    task automatic count_state(input logic [2:0] s, input int limit, output int n);
        n = 0;
        while (state == s && n < limit) begin
            @(posedge hz100);
            #1;
            n++;
        end
    endtask

    initial begin
        logic wr, clr;
        int   n;
        int   bad;

        reset       = 1'b1;
        key_valid   = 1'b0;
        key_code    = 5'd0;
        stored_code = 32'h12345678;
        idle_cycles(2);
        reset = 1'b0;
        check_reset_values("reset");

        // {key, state, digit_idx, tries, code_wr, code_clr}
        tbl.push_back('{5'd9,  3'd0, 3'd1, 2'd3, 1'b1, 1'b0});
        tbl.push_back('{5'd17, 3'd0, 3'd0, 2'd3, 1'b0, 1'b1});
        for (int d = 1; d <= 7; d++) tbl.push_back('{5'(d), 3'd0, 3'(d), 2'd3, 1'b1, 1'b0});
        tbl.push_back('{5'd16, 3'd0, 3'd7, 2'd3, 1'b0, 1'b0});  // START with 7 digits
        tbl.push_back('{5'd19, 3'd0, 3'd7, 2'd3, 1'b0, 1'b0});
        tbl.push_back('{5'd8,  3'd0, 3'd0, 2'd3, 1'b1, 1'b0});  // count 8 shows as 0
        tbl.push_back('{5'd5,  3'd0, 3'd0, 2'd3, 1'b1, 1'b0});  // saturated
        tbl.push_back('{5'd16, 3'd1, 3'd0, 2'd3, 1'b0, 1'b0});
        tbl.push_back('{5'd5,  3'd1, 3'd0, 2'd3, 1'b0, 1'b0});
        tbl.push_back('{5'd16, 3'd2, 3'd0, 2'd3, 1'b0, 1'b0});
        for (int d = 1; d <= 4; d++) tbl.push_back('{5'(d), 3'd2, 3'(d), 2'd3, 1'b0, 1'b0});
        tbl.push_back('{5'd17, 3'd2, 3'd0, 2'd3, 1'b0, 1'b0});
        tbl.push_back('{5'd18, 3'd2, 3'd0, 2'd3, 1'b0, 1'b0});
        for (int d = 1; d <= 7; d++) tbl.push_back('{5'(d), 3'd2, 3'(d), 2'd3, 1'b0, 1'b0});
        tbl.push_back('{5'd8,  3'd3, 3'd0, 2'd3, 1'b0, 1'b0});

        foreach (tbl[i]) begin
            press(tbl[i].kc, wr, clr);
            chk($sformatf("vec%0d_strobes", i), {30'd0, wr, clr}, {30'd0, tbl[i].wr, tbl[i].clr});
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("vec%0d_idx", i), 32'(digit_idx), 32'(tbl[i].idx));
            chk($sformatf("vec%0d_tries", i), 32'(tries_left), 32'(tbl[i].tr));
            chk($sformatf("vec%0d_unlocked", i), 32'(unlocked), 32'(tbl[i].st == 3'd3));
        end

        // OPEN lasts exactly 500 cycles.
        count_state(3'd3, 600, n);
        chk("open_len", 32'(n), 32'd500);
        chk("open_after", 32'(state), 32'd1);

        // Key on the final OPEN cycle: expiry wins, SET dropped.
        enter_code(32'h12345678);
        idle_cycles(499);
        chk("coll_pre", 32'(state), 32'd3);
        press(5'd18, wr, clr);
        chk("coll_clr", 32'(clr), 32'd0);
        chk("coll_state", 32'(state), 32'd1);

        // SET during OPEN.
        enter_code(32'h12345678);
        press(5'd18, wr, clr);
        chk("open_set_clr", 32'(clr), 32'd1);
        chk("open_set_state", 32'(state), 32'd0);
        chk("open_set_idx", 32'(digit_idx), 32'd0);
        program_code();
        chk("reprog_state", 32'(state), 32'd1);

        // Failure ladder: wrong digit at position 3 only resolves after digit 8.
        press(5'd16, wr, clr);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            press((i == 3) ? 5'd0 : 5'(i + 1), wr, clr);
            if (state != 3'd2) bad++;
        end
        chk("fail1_no_early", 32'(bad), 32'd0);
        press(5'd8, wr, clr);
        chk("fail1_state", 32'(state), 32'd4);
        chk("fail1_tries", 32'(tries_left), 32'd2);
        n = 0;
        while (state == 3'd4 && n < 1100) begin
            key_valid = (n == 10);
            key_code  = 5'd16;
            @(posedge hz100);
            #1;
            n++;
        end
        key_valid = 1'b0;
        chk("lockout_len", 32'(n), 32'd1000);
        chk("lockout_after", 32'(state), 32'd1);

        enter_code(32'h12345670);
        chk("fail2_state", 32'(state), 32'd4);
        chk("fail2_tries", 32'(tries_left), 32'd1);
        count_state(3'd4, 1100, n);
        enter_code(32'h02345678);
        chk("fail3_state", 32'(state), 32'd5);
        chk("fail3_tries", 32'(tries_left), 32'd0);
        chk("fail3_alarm", 32'(alarm), 32'd1);
        idle_cycles(20);
        press(5'd16, wr, clr);
        chk("alarm_hold", 32'(state), 32'd5);
        do_reset();
        check_reset_values("alarm_reset");

        // ENTRY inactivity: a key reloads the 300-cycle window.
        program_code();
        press(5'd16, wr, clr);
        idle_cycles(100);
        press(5'd1, wr, clr);
        count_state(3'd2, 400, n);
        chk("timeout_len", 32'(n), 32'd300);
        chk("timeout_state", 32'(state), 32'd1);
        chk("timeout_tries", 32'(tries_left), 32'd3);

        // Mid-operation resets.
        press(5'd16, wr, clr);
        for (int d = 1; d <= 4; d++) press(5'(d), wr, clr);
        chk("mid_entry_idx", 32'(digit_idx), 32'd4);
        do_reset();
        check_reset_values("entry_reset");

        program_code();
        enter_code(32'h11111111);
        chk("mid_lock_state", 32'(state), 32'd4);
        idle_cycles(5);
        do_reset();
        check_reset_values("lockout_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
